// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word width, special instruction encodings and fetch FSM states
package cpu_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] NOP_WORD  = 16'hFFFF;
    localparam logic [WORD_W-1:0] HALT_WORD = 16'h0000;
    typedef enum logic {BOOT, RUN} fetch_state_t;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: DEPTH x 16 instruction store, sync write, async read, HALT_WORD beyond DEPTH
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr full 16-bit read address; o_rdata read word
import cpu_pkg::*;
module instr_mem #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [WORD_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = 32'(i_raddr) < DEPTH ? r_mem[i_raddr[ADDR_W-1:0]] : HALT_WORD;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, boot loader FSM and instruction presentation for the control unit
// Ports: clk, rst_n (sync active-low); pc_increment/pc_load from control unit; d_bus shared data bus;
//        i_bus instruction word; pc; running (RUN state); boot_valid/boot_data/boot_last/boot_ready boot stream.
// Optional FETCH_PC_READ_EN adds pc_read, which drives pc onto d_bus while running.
import cpu_pkg::*;
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_increment,
    input  logic              pc_load,
    inout  wire  [WORD_W-1:0] d_bus,
`ifdef FETCH_PC_READ_EN
    input  logic              pc_read,
`endif
    output logic [WORD_W-1:0] i_bus,
    output logic [WORD_W-1:0] pc,
    output logic              running,
    input  logic              boot_valid,
    input  logic [WORD_W-1:0] boot_data,
    input  logic              boot_last,
    output logic              boot_ready
);
    fetch_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_boot_addr, w_boot_addr_nxt;
    logic [WORD_W-1:0] r_pc, w_pc_nxt, w_mem_rd;
    logic              r_armed, w_run, w_accept;
    always_comb begin
        w_run           = r_state == RUN;
        // rst_n gates the write so a reset edge never commits a stray boot word
        w_accept        = rst_n && !w_run && r_armed && boot_valid;
        w_state_nxt     = w_accept && (boot_last || r_boot_addr == ADDR_W'(DEPTH-1)) ? RUN : r_state;
        w_boot_addr_nxt = w_accept ? r_boot_addr + 1'b1 : r_boot_addr;
        w_pc_nxt        = !w_run ? '0 : pc_load ? d_bus : pc_increment ? r_pc + 16'd1 : r_pc;
    end
    // r_armed delays boot_ready by one cycle after reset release
    always_ff @(posedge clk)
        if (!rst_n) begin
            r_state     <= BOOT;
            r_boot_addr <= '0;
            r_pc        <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_boot_addr <= w_boot_addr_nxt;
            r_pc        <= w_pc_nxt;
            r_armed     <= 1'b1;
        end
    instr_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_boot_addr),
        .i_wdata (boot_data),
        .i_raddr (r_pc),
        .o_rdata (w_mem_rd)
    );
    assign pc         = r_pc;
    assign running    = w_run;
    assign boot_ready = !w_run && r_armed;
    assign i_bus      = w_run ? w_mem_rd : NOP_WORD;
`ifdef FETCH_PC_READ_EN
    assign d_bus = w_run && pc_read ? r_pc : 'z;
    a_read_load: assert property (@(posedge clk) disable iff (!rst_n) !(pc_read && pc_load));
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven and sequence checks of boot, PC update, i_bus and reset behaviour
module tb_fetch_unit;
    logic        clk = 0, rst_n = 0, pc_increment = 0, pc_load = 0;
    logic        boot_valid = 0, boot_last = 0;
    logic [15:0] d_drv = 0, boot_data = 0;
    wire  [15:0] d_bus;
    logic [15:0] i_bus, pc;
    logic        running, boot_ready;
    int          errors = 0, checks = 0;
    assign d_bus = d_drv;
    always #5 clk = ~clk;
    fetch_unit #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_increment (pc_increment),
        .pc_load      (pc_load),
        .d_bus        (d_bus),
`ifdef FETCH_PC_READ_EN
        .pc_read      (1'b0),
`endif
        .i_bus        (i_bus),
        .pc           (pc),
        .running      (running),
        .boot_valid   (boot_valid),
        .boot_data    (boot_data),
        .boot_last    (boot_last),
        .boot_ready   (boot_ready)
    );
    typedef struct {
        logic rn, inc, ld; logic [15:0] d;
        logic bv; logic [15:0] bd; logic bl;
        logic [15:0] epc, eib; logic erun, erdy, ci;
    } vec_t;
    vec_t v[$];
    task automatic chk(input string nm, input int id, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s (step %0d): got %h expected %h", nm, id, a, e);
        end
    endtask
    task automatic step(input logic rn, input logic inc, input logic ld, input logic [15:0] d,
                        input logic bv, input logic [15:0] bd, input logic bl);
        rst_n = rn; pc_increment = inc; pc_load = ld; d_drv = d;
        boot_valid = bv; boot_data = bd; boot_last = bl;
        @(posedge clk);
        #1;
    endtask
    task automatic expect_all(input int id, input logic [15:0] epc, input logic [15:0] eib,
                              input logic erun, input logic erdy, input logic ci);
        chk("pc", id, pc, epc);
        chk("running", id, {15'd0, running}, {15'd0, erun});
        chk("boot_ready", id, {15'd0, boot_ready}, {15'd0, erdy});
        if (ci) chk("i_bus", id, i_bus, eib);
    endtask
    initial begin
        //            rn inc ld d        bv bd       bl  epc      eib      run rdy ci
        v.push_back('{0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 0, 0, 1});
        v.push_back('{0, 1, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000, 16'hFFFF, 0, 0, 1});
        v.push_back('{1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 0, 1, 1});
        v.push_back('{1, 0, 0, 16'h0000, 1, 16'h1123, 0, 16'h0000, 16'hFFFF, 0, 1, 1});
        v.push_back('{1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 0, 1, 1});
        v.push_back('{1, 0, 0, 16'h0000, 1, 16'hF112, 0, 16'h0000, 16'hFFFF, 0, 1, 1});
        v.push_back('{1, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 16'h0000, 16'h1123, 1, 0, 1});
        v.push_back('{1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0001, 16'hF112, 1, 0, 1});
        v.push_back('{1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 16'hFFFF, 1, 0, 1});
        v.push_back('{1, 0, 1, 16'h0001, 0, 16'h0000, 0, 16'h0001, 16'hF112, 1, 0, 1});
        v.push_back('{1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 16'hFFFF, 1, 0, 1});
        v.push_back('{1, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1123, 1, 0, 1});
        v.push_back('{1, 0, 1, 16'hFFFF, 0, 16'h0000, 0, 16'hFFFF, 16'h0000, 1, 0, 1});
        v.push_back('{1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1123, 1, 0, 1});
        v.push_back('{1, 0, 0, 16'h0000, 1, 16'hAAAA, 1, 16'h0000, 16'h1123, 1, 0, 1});
        v.push_back('{1, 0, 1, 16'h0100, 0, 16'h0000, 0, 16'h0100, 16'h0000, 1, 0, 1});
        v.push_back('{1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0101, 16'h0000, 1, 0, 1});
        v.push_back('{1, 0, 1, 16'h0005, 0, 16'h0000, 0, 16'h0005, 16'h0000, 1, 0, 0});
        v.push_back('{0, 1, 0, 16'h0000, 1, 16'h7777, 0, 16'h0000, 16'hFFFF, 0, 0, 1});
        v.push_back('{1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 0, 1, 1});
        v.push_back('{1, 0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0000, 16'h2222, 1, 0, 1});
        v.push_back('{1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0001, 16'hF112, 1, 0, 1});
        v.push_back('{1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 16'hFFFF, 1, 0, 1});
        for (int i = 0; i < v.size(); i++) begin
            step(v[i].rn, v[i].inc, v[i].ld, v[i].d, v[i].bv, v[i].bd, v[i].bl);
            expect_all(i, v[i].epc, v[i].eib, v[i].erun, v[i].erdy, v[i].ci);
        end
        // reset mid-boot: the reset edge must not write, and unwritten words survive
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 16'h1111, 0);
        step(1, 0, 0, 0, 1, 16'h5555, 0);
        step(0, 0, 0, 0, 1, 16'h9999, 0);
        expect_all(100, 16'h0000, 16'hFFFF, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 16'h3333, 1);
        expect_all(101, 16'h0000, 16'h3333, 1, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0);
        expect_all(102, 16'h0001, 16'h5555, 1, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0);
        expect_all(103, 16'h0002, 16'hFFFF, 1, 0, 1);
        // full-depth boot without boot_last, with PC controls toggling throughout
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            step(1, i[0], i[1], 16'h0077, 1, 16'(i) ^ 16'hA5C3, 0);
            if (i < 255) expect_all(200 + i, 16'h0000, 16'hFFFF, 0, 1, 1);
            else expect_all(200 + i, 16'h0000, 16'hA5C3, 1, 0, 1);
        end
        step(1, 0, 0, 0, 1, 16'h0000, 1);
        expect_all(500, 16'h0000, 16'hA5C3, 1, 0, 1);
        step(1, 0, 1, 16'h0001, 0, 0, 0);
        expect_all(501, 16'h0001, 16'hA5C2, 1, 0, 1);
        step(1, 0, 1, 16'h0080, 0, 0, 0);
        expect_all(502, 16'h0080, 16'hA543, 1, 0, 1);
        step(1, 0, 1, 16'h00FF, 0, 0, 0);
        expect_all(503, 16'h00FF, 16'hA53C, 1, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0);
        expect_all(504, 16'h0100, 16'h0000, 1, 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
